// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encodings and default width for the shift-add multiplier
package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full-adder cell
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/ripple_adder4.sv
// rtl/ripple_adder4.sv - combinational ripple-carry adder chained from full-adder cells
module ripple_adder4 import mult_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .x   (x[i]),
            .y   (y[i]),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
        );
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier with start/busy/done
module shift_add_multiplier import mult_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state, state_n;
    logic [WIDTH-1:0]   m, acc, q;
    logic               c;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   add_y, add_sum;
    logic               add_cout;
    logic               last_iter;

    assign add_y     = q[0] ? m : '0;
    assign last_iter = (cnt == CNT_W'(1));

    // C is cleared by every shift, so it supplies the zero carry-in of each iteration
    ripple_adder4 #(.WIDTH(WIDTH)) u_adder (
        .x   (acc),
        .y   (add_y),
        .cin (c),
        .sum (add_sum),
        .cout(add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m       <= '0;
            acc     <= '0;
            c       <= 1'b0;
            q       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m   <= a;
                        q   <= b;
                        acc <= '0;
                        c   <= 1'b0;
                        cnt <= CNT_W'(WIDTH);
                    end
                end
                S_RUN: begin
                    c   <= 1'b0;
                    acc <= {add_cout, add_sum[WIDTH-1:1]};
                    q   <= {add_sum[0], q[WIDTH-1:1]};
                    cnt <= cnt - CNT_W'(1);
                    // Capture the post-shift {ACC,Q} so product is already valid while done is high
                    if (last_iter) begin
                        product <= {add_cout, add_sum, q[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
